// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the decode hazard controller
package core_pkg;

   localparam int REG_ADDR_W = 5;

   // One in-flight instruction as seen by the scoreboard
   typedef struct packed {
      logic                  v;
      logic [REG_ADDR_W-1:0] rd;
      logic                  wr;
      logic                  ld;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB write-tracking pipe and RAW match; HAZARD_FORWARD_EN limits stalls to load-use
import core_pkg::*;

module hazard_scoreboard (
   input  logic                  clk,
   input  logic                  rst,
   input  sb_entry_t             dec_entry,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic                  use_rs1,
   input  logic                  use_rs2,
   output logic                  hazard
);

   // Index 0 = EX, 1 = MEM, 2 = WB. WB is never in the stall mask because the
   // register file writes through on the same edge decode advances.
`ifdef HAZARD_FORWARD_EN
   localparam logic [2:0] STALL_STAGES = 3'b001;
   localparam logic       LOAD_ONLY    = 1'b1;
`else
   localparam logic [2:0] STALL_STAGES = 3'b011;
   localparam logic       LOAD_ONLY    = 1'b0;
`endif

   sb_entry_t pipe_q [3];
   sb_entry_t pipe_d [3];

   function automatic logic src_match(input sb_entry_t e, input logic [REG_ADDR_W-1:0] r,
                                      input logic use_r);
      return e.v & e.wr & (e.rd == r) & (r != '0) & use_r;
   endfunction

   // Advance the pipe one stage per clock
   always_comb begin
      pipe_d[0] = dec_entry;
      pipe_d[1] = pipe_q[0];
      pipe_d[2] = pipe_q[1];
   end

   // Pipe registers; reset empties every stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 3; s++) pipe_q[s] <= SB_EMPTY;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   // Any producer in a stalling stage whose result decode needs
   always_comb begin
      hazard = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (STALL_STAGES[s] && (pipe_q[s].ld || !LOAD_ONLY) &&
             (src_match(pipe_q[s], rs1, use_rs1) || src_match(pipe_q[s], rs2, use_rs2)))
            hazard = 1'b1;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - decode stall/flush/redirect sequencer; HAZARD_FORWARD_EN selects load-use-only stalls
import core_pkg::*;

module hazard_controller #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_ADDR_W-1:0]  id_rs1,
   input  logic [REG_ADDR_W-1:0]  id_rs2,
   input  logic [REG_ADDR_W-1:0]  id_rd,
   input  logic                   id_use_rs1,
   input  logic                   id_use_rs2,
   input  logic                   id_reg_write,
   input  logic                   id_load,
   input  logic                   id_jal,
   input  logic                   id_jalr,
   input  logic                   id_branch_on,
   input  logic                   id_branch_result,
   output logic                   pc_en,
   output logic                   ifid_en,
   output logic                   ifid_flush,
   output logic                   id_valid,
   output logic                   redirect,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   hz_state_e              state_q, state_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   hazard;
   logic                   dec_live;
   logic                   stall;
   logic                   take;
   sb_entry_t              dec_entry;

   hazard_scoreboard u_sb (
      .clk       (clk),
      .rst       (rst),
      .dec_entry (dec_entry),
      .rs1       (id_rs1),
      .rs2       (id_rs2),
      .use_rs1   (id_use_rs1),
      .use_rs2   (id_use_rs2),
      .hazard    (hazard)
   );

   // Only a real instruction in decode (not the fill slot or a squashed NOP) can stall or redirect
   always_comb begin
      dec_live = (state_q == ST_IDLE);
      stall    = dec_live & hazard;
      take     = dec_live & ~stall & (id_jal | id_jalr | (id_branch_on & id_branch_result));
   end

   // Next-state and output decode; reset forces the quiescent output pattern immediately
   always_comb begin
      state_d    = state_q;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      id_valid   = 1'b0;
      redirect   = 1'b0;
      case (state_q)
         ST_START: state_d = ST_IDLE;
         ST_IDLE: begin
            if (stall) begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
            end else begin
               id_valid = 1'b1;
               if (take) begin
                  redirect   = 1'b1;
                  ifid_flush = 1'b1;
                  state_d    = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (!rst) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         id_valid   = 1'b0;
         redirect   = 1'b0;
      end
   end

   // Entry pushed into EX: a bubble whenever decode does not issue
   always_comb begin
      dec_entry.v  = id_valid;
      dec_entry.rd = id_rd;
      dec_entry.wr = id_reg_write;
      dec_entry.ld = id_load;
   end

   // Saturating stall-cycle counter
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_START;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
